dff_pipe_const: RTL and testbench
=================================

// Module: dff_pipe_const
// PURPOSE
//  Parametrised successor of the single-bit constant-set flop: WIDTH-bit, DEPTH-stage
//  register pipeline with async active-low reset to RESET_VAL, synchronous set to SET_VAL,
//  load enable and per-stage valid tracking. A stability monitor flags when q has held
//  one value for STABLE_CYCLES consecutive clocks. Used as a synthesis-optimisation test
//  vehicle: constant-propagation, retiming and flop-removal across sequential stages.
// PARAMETERS
//  WIDTH          4      data width of every stage
//  DEPTH          3      number of pipeline stages (>=1); latency d->q in enabled cycles
//  RESET_VAL      4'h0   value loaded into all stages on reset_n low
//  SET_VAL        4'hF   value loaded into all stages on synchronous set
//  STABLE_CYCLES  8      hold count for q_const (>=1)
// PORTS
//  clk        in   1                   rising-edge clock
//  reset_n    in   1                   asynchronous, active-low reset
//  set        in   1                   synchronous, active-high; forces all stages to SET_VAL
//  en         in   1                   shift enable
//  d          in   WIDTH               data into stage 0
//  q          out  WIDTH               last-stage data
//  q_valid    out  1                   last stage holds data shifted from d or SET_VAL
//  q_const    out  1                   q unchanged for STABLE_CYCLES clocks
//  const_cnt  out  $clog2(STABLE_CYCLES+1)  current stability count
// BEHAVIOUR
//  - Reset (reset_n=0, async, any time incl. mid-shift): all stages=RESET_VAL, all valid=0,
//    const_cnt=0, q_const=0. Outputs update without a clock edge.
//  - Priority per edge: reset_n > set > en > hold.
//  - set=1: all stages<=SET_VAL, all valid<=1 on that edge, regardless of en/d.
//  - set=0,en=1: stage0<=d, valid0<=1; stage[i]<=stage[i-1], valid[i]<=valid[i-1].
//  - set=0,en=0: stages and valid hold.
//  - Latency: d sampled at enabled edge k appears on q after the DEPTH-th enabled edge.
//    Disabled cycles stall the pipe; they add no data and do not drop data.
//  - q = stage[DEPTH-1]; q_valid = valid[DEPTH-1]; both registered, no comb path d->q.
//  - Stability monitor: compare next-q to current q at each edge:
//    differs -> const_cnt<=0; equal and const_cnt<STABLE_CYCLES -> const_cnt+1;
//    equal and saturated -> hold. q_const = (const_cnt==STABLE_CYCLES), combinational
//    from the register, so it rises STABLE_CYCLES edges after q last changed.
//  - set while q already == SET_VAL does not reset const_cnt (value unchanged).
//  - Counter saturates, never wraps. No other state machine.
//  - Reset deassertion is synchronised externally; block does not re-synchronise it.
// STRUCTURE
//  - Package dff_const_pkg: default WIDTH/DEPTH/RESET_VAL/SET_VAL/STABLE_CYCLES
//    constants and the counter-width localparam helper.
//  - Sub-module dff_stage: one WIDTH-bit register + valid bit, async active-low reset,
//    sync set, enable; instantiated DEPTH times in a generate loop.
//  - Top holds the generate chain and the stability counter only.
// TESTING (WIDTH=4, DEPTH=3, RESET_VAL=0, SET_VAL=F, STABLE_CYCLES=8)
//  1 reset_n=0 -> q=0, q_valid=0, const_cnt=0 immediately; release, en=0 8 clocks ->
//    q_const=1 at 8th edge, q stays 0.
//  2 en=1, d=1,2,3,4,5 on successive edges -> q=1 after 3rd edge, then 2,3,4,5;
//    q_valid rises on 3rd edge; const_cnt stays 0 while q changes.
//  3 d=A, toggle en 1,0,1,0,1 -> q=A only after 3rd enabled edge; stalls hold q.
//  4 set=1 one cycle with en=1,d=5 -> all stages=F, q=F, q_valid=1 next edge;
//    set asserted again 4 cycles later -> const_cnt not cleared, q_const at 8 edges.
//  5 reset_n pulsed low mid-shift between edges -> q=0, q_valid=0, const_cnt=0 at once;
//    pipe refills with 3-edge latency after release.
//  6 hold d=7, en=1 for 20 edges -> const_cnt saturates at 8, never wraps to 0.

Source files
------------

// File: rtl/dff_const_pkg.sv
`default_nettype none
// ============================================================================
//  dff_const_pkg
//  Default parameters and helper for the constant-set register pipeline.
//  Revision: 1.0
// ============================================================================
package dff_const_pkg;

  localparam int          DEF_WIDTH         = 4;
  localparam int          DEF_DEPTH         = 3;
  localparam logic [3:0]  DEF_RESET_VAL     = 4'h0;
  localparam logic [3:0]  DEF_SET_VAL       = 4'hF;
  localparam int          DEF_STABLE_CYCLES = 8;

  // Width of a counter that must represent 0..stable_cycles inclusive.
  function automatic int cnt_w(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage : dff_const_pkg
`default_nettype wire

// File: rtl/dff_stage.sv
`default_nettype none
// ============================================================================
//  dff_stage
//  One pipeline stage: data register plus valid bit, async reset, sync set.
//  Revision: 1.0
// ============================================================================
module dff_stage
  import dff_const_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
  parameter logic [WIDTH-1:0] SET_VAL   = WIDTH'(DEF_SET_VAL)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_d;
  logic             valid_q;

  // Set beats enable; a set stage is considered valid data.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (set) begin
      data_d  = SET_VAL;
      valid_d = 1'b1;
    end else if (en) begin
      data_d  = d;
      valid_d = d_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q       = data_q;
  assign q_valid = valid_q;

endmodule : dff_stage
`default_nettype wire

// File: rtl/dff_pipe_const.sv
`default_nettype none
// ============================================================================
//  dff_pipe_const
//  DEPTH-stage register pipeline with valid tracking and a q-stability monitor.
//  Revision: 1.0
// ============================================================================
module dff_pipe_const
  import dff_const_pkg::*;
#(
  parameter int               WIDTH         = DEF_WIDTH,
  parameter int               DEPTH         = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL     = WIDTH'(DEF_RESET_VAL),
  parameter logic [WIDTH-1:0] SET_VAL       = WIDTH'(DEF_SET_VAL),
  parameter int               STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            set,
  input  logic                            en,
  input  logic [WIDTH-1:0]                d,
  output logic [WIDTH-1:0]                q,
  output logic                            q_valid,
  output logic                            q_const,
  output logic [cnt_w(STABLE_CYCLES)-1:0] const_cnt
);

  localparam int               CNT_W  = cnt_w(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] stage_data  [DEPTH];
  logic             stage_valid [DEPTH];
  logic [WIDTH-1:0] last_in;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] const_cnt_d;
  logic [CNT_W-1:0] const_cnt_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      dff_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL),
        .SET_VAL   (SET_VAL)
      ) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (set),
        .en      (en),
        .d       (d),
        .d_valid (1'b1),
        .q       (stage_data[i]),
        .q_valid (stage_valid[i])
      );
    end else begin : g_body
      dff_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL),
        .SET_VAL   (SET_VAL)
      ) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (set),
        .en      (en),
        .d       (stage_data[i-1]),
        .d_valid (stage_valid[i-1]),
        .q       (stage_data[i]),
        .q_valid (stage_valid[i])
      );
    end
  end

  // Input feeding the last stage, needed to predict q one edge ahead.
  if (DEPTH == 1) begin : g_last_in_single
    assign last_in = d;
  end else begin : g_last_in_chain
    assign last_in = stage_data[DEPTH-2];
  end

  always_comb begin
    q_next = q;
    if (set) begin
      q_next = SET_VAL;
    end else if (en) begin
      q_next = last_in;
    end
  end

  // Saturating run-length of an unchanged q; a set to the current value is no change.
  always_comb begin
    const_cnt_d = const_cnt_q;
    if (q_next != q) begin
      const_cnt_d = '0;
    end else if (const_cnt_q < CNT_MAX) begin
      const_cnt_d = const_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      const_cnt_q <= '0;
    end else begin
      const_cnt_q <= const_cnt_d;
    end
  end

  assign q         = stage_data[DEPTH-1];
  assign q_valid   = stage_valid[DEPTH-1];
  assign const_cnt = const_cnt_q;
  assign q_const   = (const_cnt_q == CNT_MAX);

endmodule : dff_pipe_const
`default_nettype wire

// File: tb/tb_dff_pipe_const.sv
`default_nettype none
// ============================================================================
//  tb_dff_pipe_const
//  Directed self-checking bench for dff_pipe_const (4-bit, 3 stages, hold 8).
//  Revision: 1.0
// ============================================================================
module tb_dff_pipe_const;

  logic       clk;
  logic       reset_n;
  logic       set;
  logic       en;
  logic [3:0] d;
  logic [3:0] q;
  logic       q_valid;
  logic       q_const;
  logic [3:0] const_cnt;

  int n_checks;
  int n_fail;

  dff_pipe_const #(
    .WIDTH         (4),
    .DEPTH         (3),
    .RESET_VAL     (4'h0),
    .SET_VAL       (4'hF),
    .STABLE_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .set       (set),
    .en        (en),
    .d         (d),
    .q         (q),
    .q_valid   (q_valid),
    .q_const   (q_const),
    .const_cnt (const_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b1;
    set      = 1'b0;
    en       = 1'b0;
    d        = 4'h0;

    // 1: async reset before any clock edge, then idle until q_const.
    #2 reset_n = 1'b0;
    #1;
    check("rst_q",       32'(q),         32'h0);
    check("rst_qvalid",  32'(q_valid),   32'h0);
    check("rst_cnt",     32'(const_cnt), 32'h0);
    check("rst_qconst",  32'(q_const),   32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("idle_cnt",    32'(const_cnt), 32'(k));
      check("idle_qconst", 32'(q_const),   (k == 8) ? 32'h1 : 32'h0);
      check("idle_q",      32'(q),         32'h0);
    end

    // 2: shift 1..5 (then hold 5) -> q follows three enabled edges later.
    en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      d = (k <= 5) ? 4'(k) : 4'h5;
      tick();
      check("shift_qvalid", 32'(q_valid), (k >= 3) ? 32'h1 : 32'h0);
      if (k >= 3) begin
        check("shift_q",   32'(q),         32'(k - 2));
        check("shift_cnt", 32'(const_cnt), 32'h0);
      end
    end

    // 3: stalls hold the pipe; A emerges on the third enabled edge only.
    d = 4'hA;
    for (int k = 1; k <= 5; k++) begin
      en = ~k[0] ? 1'b0 : 1'b1;
      tick();
      check("stall_q", 32'(q), (k == 5) ? 32'hA : 32'h5);
    end

    // 4: set overrides en/d; a repeated set at F leaves the counter running.
    set = 1'b1;
    en  = 1'b1;
    d   = 4'h5;
    tick();
    check("set_q",      32'(q),         32'hF);
    check("set_qvalid", 32'(q_valid),   32'h1);
    check("set_cnt",    32'(const_cnt), 32'h0);
    set = 1'b0;
    en  = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      set = (k == 5);
      en  = (k == 5);
      tick();
      if (k == 5) check("reset_cnt_kept", 32'(const_cnt), 32'h4);
      if (k == 8) check("set_qconst_lo",  32'(q_const),   32'h0);
      if (k == 9) check("set_qconst_hi",  32'(q_const),   32'h1);
    end
    set = 1'b0;
    en  = 1'b0;

    // 5: async reset between edges mid-shift, then refill.
    en = 1'b1;
    d  = 4'h3;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_q",      32'(q),         32'h0);
    check("mid_rst_qvalid", 32'(q_valid),   32'h0);
    check("mid_rst_cnt",    32'(const_cnt), 32'h0);
    #1 reset_n = 1'b1;
    d = 4'h9;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("refill_q",      32'(q),         (k == 3) ? 32'h9 : 32'h0);
      check("refill_qvalid", 32'(q_valid),   (k == 3) ? 32'h1 : 32'h0);
      check("refill_cnt",    32'(const_cnt), (k == 3) ? 32'h0 : 32'(k));
    end

    // 6: constant d for 20 edges -> counter saturates at 8.
    d = 4'h7;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k >= 3) begin
        check("sat_q",   32'(q),         32'h7);
        check("sat_cnt", 32'(const_cnt), (k - 3 > 8) ? 32'h8 : 32'(k - 3));
      end
    end
    check("sat_qconst", 32'(q_const), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dff_pipe_const
`default_nettype wire
